sub_64_seq: RTL and testbench
=============================

SUB_64_SEQ -- requirements
Module: sub_64_seq

Interface
REQ-001 SHALL have parameter CHUNK_W, default 16, bits subtracted per cycle; legal values 8, 16, 32, 64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction.
REQ-005 SHALL have port a, input, 64, signed minuend.
REQ-006 SHALL have port b, input, 64, signed subtrahend.
REQ-007 SHALL have port busy, output, 1, high while a subtraction is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-009 SHALL have port diff, output, 64, a - b modulo 2^64.
REQ-010 SHALL have port overflow, output, 1, signed two's-complement overflow of a - b.
REQ-011 SHALL have port borrow, output, 1, high when unsigned a < unsigned b.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL sample start only in IDLE or DONE, and on such an edge latch a and b, clear the chunk index and enter RUN.
REQ-014 SHALL ignore start while in RUN, with no effect on operands, index or results.
REQ-015 SHALL compute, in RUN, one CHUNK_W slice per cycle, LSB slice first, as a_slice + ~b_slice + carry-in, where carry-in is 1 for slice 0 and otherwise the registered carry-out of the previous slice.
REQ-016 SHALL move from RUN to DONE on the edge that completes slice N-1, where N = 64/CHUNK_W.
REQ-017 SHALL assert done during the DONE cycle only, N rising edges after the start-sampling edge (4 for the default).
REQ-018 SHALL return from DONE to IDLE when start is low, or to RUN per REQ-013 when start is high, allowing back-to-back operations.
REQ-019 SHALL set borrow to the inverse of the final slice carry-out.
REQ-020 SHALL set overflow to the XOR of the carry into bit 63 and the carry out of bit 63.
REQ-021 SHALL update diff, overflow and borrow only on the RUN-to-DONE edge, holding them until the next completion.
REQ-022 SHALL drive busy high exactly in RUN.
REQ-023 SHALL produce correct results when changes on a and b after the start-sampling edge are ignored.

Reset
REQ-024 SHALL, on rst_n low, immediately enter IDLE and clear busy, done, diff, overflow, borrow, operand registers, index and carry.
REQ-025 SHALL discard an operation interrupted mid-RUN by reset, with no done produced.
REQ-026 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when SUB_ZERO_FLAG_EN is defined, add output zero (1 bit), reset 0 and updated per REQ-021, high when diff is all zeros, accumulated slice by slice.
REQ-028 SHALL, when SUB_ZERO_FLAG_EN is undefined, have no zero port and no zero logic.

Structure
REQ-029 SHALL place the FSM state enum and the operand width constant 64 in shared package alu_pkg.
REQ-030 SHALL instantiate one sub-module, sub_chunk, a combinational CHUNK_W-bit slice adder with inputs a, b and cin and outputs sum, cout, and c_msb (the carry into the slice MSB).

Verification
REQ-031 SHALL cover: a=5, b=3, start pulse -> done after 4 edges, diff=2, borrow=0, overflow=0.
REQ-032 SHALL cover: a=3, b=5 -> diff=0xFFFF_FFFF_FFFF_FFFE, borrow=1, overflow=0.
REQ-033 SHALL cover: a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, overflow=1, borrow=0.
REQ-034 SHALL cover: start held high continuously with a=b=7 -> done every 5th cycle, diff=0, zero=1 when SUB_ZERO_FLAG_EN is defined.
REQ-035 SHALL cover: start pulsed again mid-RUN with new operands -> ignored, first result unchanged.
REQ-036 SHALL cover: rst_n low two cycles after start -> busy=0 immediately, no done, outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU blocks: operand width, FSM state
// encoding and a parameter legality helper.
package alu_pkg;

    localparam int unsigned OpWidth = 64;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic bit chunk_w_legal(input int unsigned w);
        return (w == 8) || (w == 16) || (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK_W-bit slice adder: sum = a + b + cin, also exposing the
// carry into the slice MSB so the caller can derive signed overflow.
module sub_chunk #(
    parameter int unsigned CHUNK_W = 16
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               cout,
    output logic               c_msb
);

    logic [CHUNK_W-1:0] low_sum;
    logic [1:0]         top_sum;

    // Low CHUNK_W-1 bits first; the extra bit of low_sum is the carry into the MSB.
    assign low_sum = {1'b0, a[CHUNK_W-2:0]} + {1'b0, b[CHUNK_W-2:0]}
                   + {{(CHUNK_W-1){1'b0}}, cin};
    assign c_msb   = low_sum[CHUNK_W-1];
    assign top_sum = {1'b0, a[CHUNK_W-1]} + {1'b0, b[CHUNK_W-1]} + {1'b0, c_msb};

    assign sum  = {top_sum[0], low_sum[CHUNK_W-2:0]};
    assign cout = top_sum[1];

endmodule

// File: rtl/sub_64_seq.sv
// Multi-cycle 64-bit signed subtractor, CHUNK_W bits per cycle, LSB slice first.
// Optional zero flag output is enabled by defining SUB_ZERO_FLAG_EN.
module sub_64_seq
    import alu_pkg::*;
#(
    parameter int unsigned CHUNK_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [OpWidth-1:0] a,
    input  logic [OpWidth-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [OpWidth-1:0] diff,
    output logic               overflow,
    output logic               borrow
`ifdef SUB_ZERO_FLAG_EN
    ,
    output logic               zero
`endif
);

    localparam int unsigned NumChunks = OpWidth / CHUNK_W;
    localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

    if (!chunk_w_legal(CHUNK_W)) begin : g_bad_chunk_w
        $error("sub_64_seq: CHUNK_W must be 8, 16, 32 or 64");
    end

    state_e             state_q, state_d;
    logic [OpWidth-1:0] a_q, a_d;
    logic [OpWidth-1:0] b_q, b_d;
    logic [OpWidth-1:0] acc_q, acc_d;
    logic [OpWidth-1:0] diff_q, diff_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               borrow_q, borrow_d;
`ifdef SUB_ZERO_FLAG_EN
    logic               zacc_q, zacc_d;
    logic               zero_q, zero_d;
    logic               zero_run;
`endif

    logic [31:0]        base;
    logic [CHUNK_W-1:0] a_slice;
    logic [CHUNK_W-1:0] nb_slice;
    logic [CHUNK_W-1:0] sum;
    logic               cin;
    logic               cout;
    logic               c_msb;
    logic               last;

    assign base     = 32'(idx_q) * CHUNK_W;
    assign a_slice  = a_q[base +: CHUNK_W];
    assign nb_slice = ~b_q[base +: CHUNK_W];
    // Slice 0 gets the +1 that completes the two's-complement negation of b.
    assign cin      = (idx_q == '0) ? 1'b1 : carry_q;
    assign last     = (idx_q == LastIdx);

    sub_chunk #(
        .CHUNK_W (CHUNK_W)
    ) u_sub_chunk (
        .a     (a_slice),
        .b     (nb_slice),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .c_msb (c_msb)
    );

`ifdef SUB_ZERO_FLAG_EN
    assign zero_run = ((idx_q == '0) ? 1'b1 : zacc_q) & (sum == '0);
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        diff_d     = diff_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        borrow_d   = borrow_q;
`ifdef SUB_ZERO_FLAG_EN
        zacc_d     = zacc_q;
        zero_d     = zero_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                acc_d[base +: CHUNK_W] = sum;
                carry_d                = cout;
`ifdef SUB_ZERO_FLAG_EN
                zacc_d                 = zero_run;
`endif
                if (last) begin
                    state_d    = StDone;
                    diff_d     = acc_d;
                    overflow_d = c_msb ^ cout;
                    borrow_d   = ~cout;
`ifdef SUB_ZERO_FLAG_EN
                    zero_d     = zero_run;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            diff_q     <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            borrow_q   <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
            zacc_q     <= 1'b0;
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            diff_q     <= diff_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            borrow_q   <= borrow_d;
`ifdef SUB_ZERO_FLAG_EN
            zacc_q     <= zacc_d;
            zero_q     <= zero_d;
`endif
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign diff     = diff_q;
    assign overflow = overflow_q;
    assign borrow   = borrow_q;
`ifdef SUB_ZERO_FLAG_EN
    assign zero     = zero_q;
`endif

endmodule

// File: tb/tb_sub_64_seq.sv
// Self-checking bench for sub_64_seq: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_sub_64_seq;

    localparam int unsigned ChunkW = 16;
    localparam int          N      = 64 / ChunkW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] diff;
    logic        overflow;
    logic        borrow;
`ifdef SUB_ZERO_FLAG_EN
    logic        zero;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] prev_diff = '0;

    sub_64_seq #(
        .CHUNK_W (ChunkW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .overflow (overflow),
        .borrow   (borrow)
`ifdef SUB_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one subtraction and checks latency, held outputs and final results.
    // With glitch set, a second start with different operands is pulsed mid-RUN.
    task automatic run_op(input logic [63:0] op_a, input logic [63:0] op_b, input bit glitch);
        logic [63:0] exp_d;
        logic        exp_bo;
        logic        exp_ov;
        exp_d  = op_a - op_b;
        exp_bo = op_a < op_b;
        exp_ov = (op_a[63] != op_b[63]) && (exp_d[63] != op_a[63]);

        a     = op_a;
        b     = op_b;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = rand64();
        b     = rand64();
        check_bit("busy_after_start", busy, 1'b1);
        check_bit("no_done_after_start", done, 1'b0);
        for (int k = 1; k <= N; k++) begin
            if (glitch && k == 1) begin
                start = 1'b1;
                a     = rand64();
                b     = rand64();
            end
            if (glitch && k == 2) start = 1'b0;
            tick();
            if (k < N) begin
                check_bit("done_early", done, 1'b0);
                check_bit("busy_in_run", busy, 1'b1);
                check("diff_held", diff, prev_diff);
            end
        end
        check_bit("done_pulse", done, 1'b1);
        check_bit("busy_in_done", busy, 1'b0);
        check("diff", diff, exp_d);
        check_bit("borrow", borrow, exp_bo);
        check_bit("overflow", overflow, exp_ov);
`ifdef SUB_ZERO_FLAG_EN
        check_bit("zero", zero, exp_d == 64'd0);
`endif
        prev_diff = exp_d;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2;
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check("reset_diff", diff, 64'd0);
        check_bit("reset_borrow", borrow, 1'b0);
        check_bit("reset_overflow", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start on the first rising edge after reset release.
        run_op(64'd5, 64'd3, 1'b0);
        run_op(64'd3, 64'd5, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op(64'd0, 64'd0, 1'b0);
        run_op(64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0);

        // A start pulse during RUN must not disturb the result.
        run_op(64'd100, 64'd42, 1'b1);

        // Let the FSM return to IDLE, then a random batch.
        tick();
        check_bit("idle_busy", busy, 1'b0);
        check_bit("idle_done", done, 1'b0);
        for (int i = 0; i < 20; i++) begin
            run_op(rand64(), rand64(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Start held high: back-to-back operations, done every N+1 cycles.
        a     = 64'd7;
        b     = 64'd7;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 3 * (N + 1) - 1; k++) begin
            tick();
            check_bit("b2b_done", done, (k % (N + 1)) == N);
            check_bit("b2b_busy", busy, (k % (N + 1)) != N);
            if ((k % (N + 1)) == N) begin
                check("b2b_diff", diff, 64'd0);
`ifdef SUB_ZERO_FLAG_EN
                check_bit("b2b_zero", zero, 1'b1);
`endif
            end
        end
        start     = 1'b0;
        prev_diff = 64'd0;
        tick();
        check_bit("b2b_idle", busy, 1'b0);

        // Reset two cycles into an operation discards it.
        run_op(64'd1000, 64'd1, 1'b0);
        a     = 64'd9;
        b     = 64'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check("rst_diff", diff, 64'd0);
        check_bit("rst_borrow", borrow, 1'b0);
        check_bit("rst_overflow", overflow, 1'b0);
`ifdef SUB_ZERO_FLAG_EN
        check_bit("rst_zero", zero, 1'b0);
`endif
        for (int k = 0; k < N + 2; k++) begin
            tick();
            check_bit("rst_no_done", done, 1'b0);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        prev_diff = 64'd0;
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
